// File: rtl/csa_stream_accum_if.sv
// Operand/result handshake bundle for csa_stream_accum.
// master = producer/consumer side, slave = accumulator side.
interface csa_stream_accum_if #(
  parameter int WIDTH     = 4,
  parameter int ACC_W     = 8,
  parameter int MAX_BEATS = 4
);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_c;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_last, in_a, in_b, in_c, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_last, in_a, in_b, in_c, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/csa_stream_accum.sv
// Streaming carry-save accumulator: three operands per beat folded into
// redundant sum/carry registers, resolved by a single add after the last beat.
module csa_stream_accum #(
  parameter int WIDTH     = 4,
  parameter int MAX_BEATS = 4,
  parameter int ACC_W     = 8
) (
  input logic               clk,
  input logic               rst,
  csa_stream_accum_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  typedef struct packed {
    logic [ACC_W-1:0] s;
    logic [ACC_W-1:0] k;
  } csa_t;

  state_t           state_r;
  logic [ACC_W-1:0] sum_r;
  logic [ACC_W-1:0] carry_r;
  logic [CNT_W-1:0] count_r;
  logic             ovf_r;
  csa_t             l1_s;
  csa_t             l2_s;
  csa_t             l3_s;

  // 3:2 compressor: per-bit sum and majority carry (carry not yet shifted)
  function automatic csa_t csa3(input logic [ACC_W-1:0] x,
                                input logic [ACC_W-1:0] y,
                                input logic [ACC_W-1:0] z);
    csa_t r;
    r.s = x ^ y ^ z;
    r.k = (x & y) | (x & z) | (y & z);
    return r;
  endfunction

  // Compressor tree: operands, then running sum, then running carry
  always_comb begin
    l1_s = csa3(ACC_W'(bus.in_a), ACC_W'(bus.in_b), ACC_W'(bus.in_c));
    l2_s = csa3(l1_s.s, l1_s.k << 1'b1, sum_r);
    l3_s = csa3(l2_s.s, l2_s.k << 1'b1, carry_r);
  end

  assign bus.in_ready = ~rst & ((state_r == IDLE) | (state_r == ACCUM));

  // Transaction FSM with accumulator and registered result port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      sum_r         <= '0;
      carry_r       <= '0;
      count_r       <= '0;
      ovf_r         <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
      bus.out_count <= '0;
      bus.out_ovf   <= 1'b0;
    end else begin
      case (state_r)
        IDLE, ACCUM: begin
          if (bus.in_valid) begin
            sum_r   <= l3_s.s;
            carry_r <= l3_s.k << 1'b1;
            count_r <= (count_r == MAX_CNT) ? MAX_CNT : count_r + CNT_W'(1);
            ovf_r   <= ovf_r | (count_r == MAX_CNT);
            state_r <= bus.in_last ? RESOLVE : ACCUM;
          end else begin
            state_r <= state_r;
          end
        end
        RESOLVE: begin
          bus.out_sum   <= sum_r + carry_r;
          bus.out_count <= count_r;
          bus.out_ovf   <= ovf_r;
          bus.out_valid <= 1'b1;
          state_r       <= HOLD;
        end
        HOLD: begin
          // Result fields are left as-is so the consumer can still read them
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            sum_r         <= '0;
            carry_r       <= '0;
            count_r       <= '0;
            ovf_r         <= 1'b0;
            state_r       <= IDLE;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end
endmodule
